// File: rtl/sysmem_bank.sv
// Single-clock system memory bank for the PicoRV32 native bus: byte-strobed
// writes, base-address decode with error response, optional zero-clear after reset.
module sysmem_bank #(
    parameter int          NUM_BYTES      = 4,
    parameter int          DEPTH          = 1024,
    parameter int          READ_LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b0,
    parameter              INIT_FILE      = ""
) (
    input  logic                   clka,
    input  logic                   rsta_n,
    input  logic                   mem_valid,
    input  logic [31:0]            mem_addr,
    input  logic [8*NUM_BYTES-1:0] mem_wdata,
    input  logic [NUM_BYTES-1:0]   mem_wstrb,
    output logic                   mem_ready,
    output logic [8*NUM_BYTES-1:0] mem_rdata,
    output logic                   err,
    output logic                   busy
);

    localparam int DW    = 8 * NUM_BYTES;
    localparam int OFS   = $clog2(NUM_BYTES);
    localparam int AW    = $clog2(DEPTH);
    localparam int TAGLO = OFS + AW;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    state_t               state_reg, state_next;
    logic [AW-1:0]        clr_cnt_reg;
    logic                 miss_reg;
    logic                 use_ram_reg;
    logic [DW-1:0]        rdata_reg;

    logic [AW-1:0]        word_idx;
    logic                 hit;
    logic                 accept;
    logic                 is_write;

    logic [NUM_BYTES-1:0] ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic                 ram_re;
    logic [DW-1:0]        ram_q;
    logic [DW-1:0]        mem [DEPTH];

    assign word_idx = mem_addr[TAGLO-1:OFS];
    assign hit      = (mem_addr[31:TAGLO] == BASE_ADDR[31:TAGLO]);
    assign accept   = (state_reg == IDLE) && mem_valid;
    assign is_write = |mem_wstrb;

    // Byte-offset bits only select a lane inside the word and are otherwise don't-care.
    generate
        if (OFS > 0) begin : g_unused
            logic unused_lo;
            assign unused_lo = ^mem_addr[OFS-1:0];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ram_we     = '0;
        ram_addr   = word_idx;
        ram_wdata  = mem_wdata;
        ram_re     = 1'b0;
        case (state_reg)
            CLEAR: begin
                ram_we    = '1;
                ram_addr  = clr_cnt_reg;
                ram_wdata = '0;
                if (clr_cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (mem_valid) begin
                    if (hit && is_write) begin
                        ram_we     = mem_wstrb;
                        state_next = RESP;
                    end else if (hit) begin
                        ram_re     = 1'b1;
                        state_next = (READ_LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_reg   <= RST_STATE;
            clr_cnt_reg <= '0;
            miss_reg    <= 1'b0;
            use_ram_reg <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CLEAR) begin
                clr_cnt_reg <= clr_cnt_reg + AW'(1);
            end
            if (accept) begin
                miss_reg <= !hit;
            end
            // With one-cycle latency the RAM output register itself drives mem_rdata
            // until a miss forces the held value to zero.
            if (accept && !hit) begin
                rdata_reg   <= '0;
                use_ram_reg <= 1'b0;
            end else if (ram_re && (READ_LATENCY == 1)) begin
                use_ram_reg <= 1'b1;
            end
            if (state_reg == WAIT) begin
                rdata_reg <= ram_q;
            end
        end
    end

    // Storage: synchronous read and byte-enabled synchronous write, no reset.
    always_ff @(posedge clka) begin
        if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (ram_we[i]) begin
                mem[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
            end
        end
    end

    assign mem_ready = (state_reg == RESP);
    assign err       = mem_ready && miss_reg;
    assign busy      = (state_reg == CLEAR);
    assign mem_rdata = use_ram_reg ? ram_q : rdata_reg;

endmodule

// File: tb/tb_sysmem_bank.sv
// Directed bench for sysmem_bank: bank A clears on reset with one-cycle reads,
// bank B is small with two-cycle reads and no clear.
module tb_sysmem_bank;

    logic        clk;
    logic        a_rst_n, b_rst_n;
    logic        a_valid, b_valid;
    logic [31:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_wstrb, b_wstrb;
    logic        a_ready, b_ready;
    logic [31:0] a_rdata, b_rdata;
    logic        a_err, b_err;
    logic        a_busy, b_busy;

    int          nvec = 0;
    int          nmis = 0;

    int          lat;
    logic [31:0] rd;
    logic        e;
    int          e1, e2, pulses, nbusy;
    logic [31:0] d1, d2;

    sysmem_bank #(
        .NUM_BYTES(4), .DEPTH(1024), .READ_LATENCY(1),
        .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
    ) dut_a (
        .clka(clk), .rsta_n(a_rst_n), .mem_valid(a_valid), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_ready(a_ready),
        .mem_rdata(a_rdata), .err(a_err), .busy(a_busy)
    );

    sysmem_bank #(
        .NUM_BYTES(4), .DEPTH(16), .READ_LATENCY(2),
        .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b0), .INIT_FILE("")
    ) dut_b (
        .clka(clk), .rsta_n(b_rst_n), .mem_valid(b_valid), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_ready(b_ready),
        .mem_rdata(b_rdata), .err(b_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus transaction on bank A (sel=0) or B (sel=1); lat counts edges
    // from the first edge with valid high up to the edge that raises ready.
    task automatic xfer(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata,
                        output logic eo, output int lo);
        bit ok;
        ok = 1'b0;
        lo = 0;
        @(negedge clk);
        if (sel) begin
            b_valid = 1'b1; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb;
        end else begin
            a_valid = 1'b1; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
        end
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            lo++;
            if (sel ? b_ready : a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("xfer_done", 32'(ok), 32'd1);
        rdata = sel ? b_rdata : a_rdata;
        eo    = sel ? b_err : a_err;
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_one_cycle", 32'(sel ? b_ready : a_ready), 32'd0);
        check("err_idle_low", 32'(sel ? b_err : a_err), 32'd0);
        $display("xfer bank=%0d addr=%08h wstrb=%b rdata=%08h err=%0d lat=%0d",
                 sel, addr, wstrb, rdata, eo, lo);
    endtask

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_valid = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_a_err", 32'(a_err), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd1);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);

        // Release mid-high: a read issued during clear waits 1024 clear edges plus its accept edge.
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        xfer(0, 32'h3FC, 32'h0, 4'b0000, rd, e, lat);
        check("clr_read_lat", 32'(lat), 32'd1025);
        check("clr_read_data", rd, 32'h0);
        check("clr_read_err", 32'(e), 32'd0);

        xfer(0, 32'h10, 32'hDEADBEEF, 4'b1111, rd, e, lat);
        check("wr_lat", 32'(lat), 32'd1);
        check("wr_err", 32'(e), 32'd0);
        xfer(0, 32'h10, 32'h0, 4'b0000, rd, e, lat);
        check("rd_lat", 32'(lat), 32'd1);
        check("rd_data", rd, 32'hDEADBEEF);

        xfer(0, 32'h10, 32'h00AA0000, 4'b0100, rd, e, lat);
        check("bw_rdata_kept", rd, 32'hDEADBEEF);
        xfer(0, 32'h10, 32'h0, 4'b0000, rd, e, lat);
        check("bw_data", rd, 32'hDEAABEEF);
        xfer(0, 32'h12, 32'h0, 4'b0000, rd, e, lat);
        check("bw_unaligned", rd, 32'hDEAABEEF);

        xfer(0, 32'h0, 32'h0BADF00D, 4'b1111, rd, e, lat);
        xfer(0, 32'h1000, 32'h12345678, 4'b1111, rd, e, lat);
        check("miss_lat", 32'(lat), 32'd1);
        check("miss_err", 32'(e), 32'd1);
        check("miss_rdata", rd, 32'h0);
        xfer(0, 32'h0, 32'h0, 4'b0000, rd, e, lat);
        check("miss_untouched", rd, 32'h0BADF00D);
        check("hit_err", 32'(e), 32'd0);

        xfer(1, 32'h0, 32'h11223344, 4'b1111, rd, e, lat);
        check("b_wr_lat", 32'(lat), 32'd1);
        xfer(1, 32'h4, 32'h55667788, 4'b1111, rd, e, lat);

        // Two reads with valid held high throughout.
        e1 = -1; e2 = -1; pulses = 0; d1 = '0; d2 = '0;
        @(negedge clk);
        b_valid = 1'b1; b_addr = 32'h0; b_wstrb = 4'b0000; b_wdata = '0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (b_ready) begin
                pulses++;
                if (e1 < 0) begin
                    e1 = n; d1 = b_rdata; b_addr = 32'h4;
                end else if (e2 < 0) begin
                    e2 = n; d2 = b_rdata; b_valid = 1'b0;
                end
            end
        end
        $display("rl2 b2b first=%0d second=%0d d1=%08h d2=%08h pulses=%0d", e1, e2, d1, d2, pulses);
        check("rl2_first_edge", 32'(e1), 32'd2);
        check("rl2_second_edge", 32'(e2), 32'd5);
        check("rl2_data0", d1, 32'h11223344);
        check("rl2_data1", d2, 32'h55667788);
        check("rl2_pulses", 32'(pulses), 32'd2);

        // Reset during the WAIT cycle of a read drops the response.
        @(negedge clk);
        b_valid = 1'b1; b_addr = 32'h0; b_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        check("abort_wait_rdy", 32'(b_ready), 32'd0);
        b_rst_n = 1'b0;
        #1;
        check("abort_rdata", b_rdata, 32'h0);
        check("abort_ready", 32'(b_ready), 32'd0);
        b_valid = 1'b0;
        @(negedge clk);
        b_rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (b_ready) pulses++;
        end
        $display("abort ready_pulses=%0d rdata=%08h", pulses, b_rdata);
        check("abort_no_pulse", 32'(pulses), 32'd0);
        check("abort_rdata_hold", b_rdata, 32'h0);
        xfer(1, 32'h4, 32'h0, 4'b0000, rd, e, lat);
        check("b_rd_lat", 32'(lat), 32'd2);
        check("b_persist", rd, 32'h55667788);
        xfer(1, 32'h40, 32'h0, 4'b0000, rd, e, lat);
        check("b_miss_lat", 32'(lat), 32'd1);
        check("b_miss_err", 32'(e), 32'd1);
        check("b_miss_rdata", rd, 32'h0);

        // Reset in the middle of a clear restarts it from index 0.
        @(posedge clk);
        #1;
        a_rst_n = 1'b0;
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        a_rst_n = 1'b0;
        #1;
        check("midclr_busy", 32'(a_busy), 32'd1);
        check("midclr_ready", 32'(a_ready), 32'd0);
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        nbusy = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            nbusy++;
            if (!a_busy) break;
        end
        $display("clear restart busy_cycles=%0d", nbusy);
        check("clr_cycles", 32'(nbusy), 32'd1024);
        xfer(0, 32'h0, 32'h0, 4'b0000, rd, e, lat);
        check("clr_overwrites", rd, 32'h0);
        check("post_clr_lat", 32'(lat), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
